// File: rtl/inst_loader.sv
// Serial instruction loader: 2-flop synced strobe/data shifted MSB-first into an INST_W frame, plus button edge detect.
// Latency: a serial edge is acted on at the 3rd clk edge after the pin rise; btn_edge follows the conditioned level by one cycle.
// Backpressure: serial edges are ignored while exec_busy=1. Optional button debounce is enabled by defining INST_LOADER_DEBOUNCE_EN.
module inst_loader #(
    parameter int INST_W          = 12,
    parameter int TIMEOUT_CYCLES  = 1024,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       ser_clk,
    input  logic       ser_in,
    input  logic       btn_in,
    input  logic       exec_busy,
    output logic [3:0] opcode,
    output logic [7:0] imm,
    output logic       inst_done,
    output logic       btn_edge,
    output logic       frame_err,
    output logic [3:0] bit_cnt
);

    localparam int          TO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [3:0]  LAST_BIT = 4'(INST_W - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_READY} state_t;

    logic [1:0]        r_sclk_s, r_sin_s, r_btn_s;
    logic              r_sclk_d;
    state_t            r_state, w_state_nxt;
    logic [INST_W-1:0] r_shift, w_shift_nxt, w_frame;
    logic [3:0]        r_bit_cnt, w_cnt_nxt;
    logic [TO_W-1:0]   r_idle_cnt, w_idle_nxt;
    logic              r_done, w_done_nxt, r_ferr, w_ferr_nxt, w_load;
    logic [3:0]        r_opcode;
    logic [7:0]        r_imm;
    logic              w_ser_edge, w_edge_acc, w_sin;
    logic              w_btn_lvl, r_lvl_d, r_btn_edge, w_priming;
    logic [2:0]        r_prime;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sclk_s <= '0;
            r_sin_s  <= '0;
            r_btn_s  <= '0;
            r_sclk_d <= 1'b0;
        end else begin
            r_sclk_s <= {r_sclk_s[0], ser_clk};
            r_sin_s  <= {r_sin_s[0], ser_in};
            r_btn_s  <= {r_btn_s[0], btn_in};
            r_sclk_d <= r_sclk_s[1];
        end
    end

    assign w_ser_edge = r_sclk_s[1] & ~r_sclk_d;
    assign w_edge_acc = w_ser_edge & ~exec_busy;
    assign w_sin      = r_sin_s[1];
    assign w_frame    = {r_shift[INST_W-2:0], w_sin};

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_bit_cnt;
        w_idle_nxt  = '0;
        w_done_nxt  = r_done;
        w_ferr_nxt  = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_edge_acc) begin
                    w_shift_nxt = {{(INST_W-1){1'b0}}, w_sin};
                    w_cnt_nxt   = 4'd1;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // A serial edge takes priority over a coincident timeout.
                if (w_edge_acc) begin
                    w_shift_nxt = w_frame;
                    if (r_bit_cnt == LAST_BIT) begin
                        w_load      = 1'b1;
                        w_done_nxt  = 1'b1;
                        w_cnt_nxt   = 4'd0;
                        w_state_nxt = S_READY;
                    end else begin
                        w_cnt_nxt = r_bit_cnt + 4'd1;
                    end
                end else if (r_idle_cnt == TO_LAST) begin
                    w_shift_nxt = '0;
                    w_cnt_nxt   = 4'd0;
                    w_ferr_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_idle_nxt = r_idle_cnt + 1'b1;
                end
            end
            S_READY: begin
                if (w_edge_acc) begin
                    w_done_nxt  = 1'b0;
                    w_shift_nxt = {{(INST_W-1){1'b0}}, w_sin};
                    w_cnt_nxt   = 4'd1;
                    w_state_nxt = S_SHIFT;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= 4'd0;
            r_idle_cnt <= '0;
            r_done     <= 1'b0;
            r_ferr     <= 1'b0;
            r_opcode   <= 4'd0;
            r_imm      <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_bit_cnt  <= w_cnt_nxt;
            r_idle_cnt <= w_idle_nxt;
            r_done     <= w_done_nxt;
            r_ferr     <= w_ferr_nxt;
            if (w_load) begin
                r_opcode <= w_frame[11:8];
                r_imm    <= w_frame[7:0];
            end
        end
    end

`ifdef INST_LOADER_DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    logic [DB_W-1:0] r_db_cnt;
    logic            r_btn_lvl;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_db_cnt  <= '0;
            r_btn_lvl <= 1'b0;
        end else if (w_priming) begin
            r_db_cnt  <= '0;
            r_btn_lvl <= r_btn_s[1];
        end else if (r_btn_s[1] != r_btn_lvl) begin
            if (r_db_cnt == DB_LAST) begin
                r_db_cnt  <= '0;
                r_btn_lvl <= r_btn_s[1];
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end else begin
            r_db_cnt <= '0;
        end
    end

    assign w_btn_lvl = r_btn_lvl;
`else
    assign w_btn_lvl = r_btn_s[1] & (DEBOUNCE_CYCLES >= 0);
`endif

    // After reset the level history is primed without pulsing, so a button held through reset gives no edge.
    assign w_priming = (r_prime != 3'd4);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_prime    <= 3'd0;
            r_lvl_d    <= 1'b0;
            r_btn_edge <= 1'b0;
        end else begin
            r_lvl_d <= w_btn_lvl;
            if (w_priming) begin
                r_prime    <= r_prime + 3'd1;
                r_btn_edge <= 1'b0;
            end else begin
                r_btn_edge <= w_btn_lvl & ~r_lvl_d;
            end
        end
    end

    assign opcode    = r_opcode;
    assign imm       = r_imm;
    assign inst_done = r_done;
    assign btn_edge  = r_btn_edge;
    assign frame_err = r_ferr;
    assign bit_cnt   = r_bit_cnt;

endmodule

// File: tb/tb_inst_loader.sv
// Directed + randomized bench for inst_loader against a frame-level reference model.
module tb_inst_loader;

    logic       clk = 1'b0;
    logic       rstn, ser_clk, ser_in, btn_in, exec_busy;
    logic [3:0] opcode, bit_cnt;
    logic [7:0] imm;
    logic       inst_done, btn_edge, frame_err;

    int n_tests = 0;
    int n_fail  = 0;
    int n_btn   = 0;
    int n_ferr  = 0;

    // Reference model: frame-level view of what has been accepted.
    logic [3:0] m_op;
    logic [7:0] m_imm;
    logic       m_done;
    logic       m_q[$];

    inst_loader dut (
        .clk       (clk),
        .rstn      (rstn),
        .ser_clk   (ser_clk),
        .ser_in    (ser_in),
        .btn_in    (btn_in),
        .exec_busy (exec_busy),
        .opcode    (opcode),
        .imm       (imm),
        .inst_done (inst_done),
        .btn_edge  (btn_edge),
        .frame_err (frame_err),
        .bit_cnt   (bit_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (btn_edge)  n_btn  <= n_btn + 1;
        if (frame_err) n_ferr <= n_ferr + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before 2ms");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "_op"},   32'(opcode),    32'(m_op));
        check({tag, "_imm"},  32'(imm),       32'(m_imm));
        check({tag, "_done"}, 32'(inst_done), 32'(m_done));
        check({tag, "_cnt"},  32'(bit_cnt),   32'(m_q.size()));
    endtask

    task automatic model_reset();
        m_op = 4'd0; m_imm = 8'd0; m_done = 1'b0; m_q.delete();
    endtask

    task automatic model_bit(input logic b);
        logic [11:0] v;
        if (exec_busy) return;
        m_done = 1'b0;
        m_q.push_back(b);
        if (m_q.size() == 12) begin
            v = '0;
            for (int i = 0; i < 12; i++) v = {v[10:0], m_q[i]};
            m_op = v[11:8]; m_imm = v[7:0]; m_done = 1'b1;
            m_q.delete();
        end
    endtask

    task automatic send_bit(input logic b);
        ser_in  = b;
        ser_clk = 1'b1;
        tick(4);
        ser_clk = 1'b0;
        tick(4);
        model_bit(b);
    endtask

    task automatic send_frame(input string tag, input logic [11:0] v, input int nbits);
        for (int i = 11; i > 11 - nbits; i--) begin
            send_bit(v[i]);
            check_model(tag);
        end
    endtask

    initial begin
        logic [11:0] v;
        int base;
        rstn = 1'b0; ser_clk = 1'b0; ser_in = 1'b0; btn_in = 1'b0; exec_busy = 1'b0;
        model_reset();
        tick(3);
        check_model("rst");
        check("rst_ferr", 32'(frame_err), 0);
        check("rst_btn",  32'(btn_edge),  0);
        rstn = 1'b1;
        tick(6);
        check_model("post_rst");

        send_frame("f805", 12'h805, 12);
        check("f805_op_const",  32'(opcode), 32'h8);
        check("f805_imm_const", 32'(imm),    32'h05);

        send_frame("f6a3", 12'h6A3, 12);
        exec_busy = 1'b1;
        send_frame("busy", 12'($urandom), 12);
        check("busy_op_const",  32'(opcode), 32'h6);
        check("busy_imm_const", 32'(imm),    32'hA3);
        exec_busy = 1'b0;

        for (int f = 0; f < 6; f++) begin
            exec_busy = ($urandom_range(0, 3) == 0);
            send_frame("rnd", 12'($urandom), 12);
        end
        exec_busy = 1'b0;

        base = n_ferr;
        send_frame("part5", 12'($urandom), 5);
        tick(1000);
        check("to_early", 32'(n_ferr - base), 0);
        tick(100);
        check("to_pulse", 32'(n_ferr - base), 1);
        m_q.delete();
        check_model("to_after");
        send_frame("to_reload", 12'($urandom), 12);

        send_frame("part7", 12'hABC, 7);
        rstn = 1'b0;
        #1;
        model_reset();
        check_model("midrst");
        check("midrst_ferr", 32'(frame_err), 0);
        tick(2);
        rstn = 1'b1;
        tick(6);
        send_frame("f1ff", 12'h1FF, 12);
        check("f1ff_op_const",  32'(opcode), 32'h1);
        check("f1ff_imm_const", 32'(imm),    32'hFF);

        base = n_btn;
        for (int k = 0; k < 3; k++) begin
            btn_in = 1'b1; tick(2);
            if (k < 2) begin btn_in = 1'b0; tick(2); end
        end
        tick(40);
        btn_in = 1'b0;
        tick(30);
`ifdef INST_LOADER_DEBOUNCE_EN
        check("bounce_edges", 32'(n_btn - base), 1);
`else
        check("bounce_edges", 32'(n_btn - base), 3);
`endif

        btn_in = 1'b1;
        rstn = 1'b0;
        tick(3);
        rstn = 1'b1;
        base = n_btn;
        tick(60);
        check("held_rst_edges", 32'(n_btn - base), 0);
        btn_in = 1'b0; tick(30);
        base = n_btn;
        btn_in = 1'b1; tick(40);
        check("press_after_hold", 32'(n_btn - base), 1);
        btn_in = 1'b0; tick(30);
        check("release_no_edge", 32'(n_btn - base), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_loader.md
INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 SHALL have parameter INST_W, default 12, instruction frame length in bits; opcode is bits [11:8], immediate/operand field is bits [7:0].
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, the number of clk cycles without a serial edge after which a partial frame is aborted.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 16, the button stability window in clk cycles; it applies only when debounce is compiled in.
REQ-004 SHALL have ports, one per line below.
- clk  input  1  system clock; all state updates on its rising edge.
- rstn  input  1  asynchronous active-low reset.
- ser_clk  input  1  asynchronous serial strobe from pin.
- ser_in  input  1  asynchronous serial data from pin, MSB first.
- btn_in  input  1  asynchronous raw execute button.
- exec_busy  input  1  controller is executing; high while the controller is outside idle.
- opcode  output  4  opcode of the last complete frame.
- imm  output  8  operand field of the last complete frame.
- inst_done  output  1  complete frame held and valid.
- btn_edge  output  1  one-cycle pulse on button press.
- frame_err  output  1  one-cycle pulse on timeout abort.
- bit_cnt  output  4  bits received in the current frame.

Function
REQ-005 SHALL pass ser_clk, ser_in and btn_in each through a 2-flop synchronizer of equal depth.
REQ-006 SHALL detect a serial edge as synced ser_clk high and one-cycle-delayed synced ser_clk low.
REQ-007 SHALL act on a serial edge at the 3rd rising clk edge after the ser_clk pin rise, counting the capturing edge as the 1st, and SHALL sample synced ser_in at that same edge.
REQ-008 SHALL implement states IDLE, SHIFT and READY.
REQ-009 IDLE: on a serial edge, SHALL shift in bit 1, set bit_cnt=1 and go to SHIFT.
REQ-010 SHIFT: on each serial edge, SHALL shift left (LSB gets the new bit) and increment bit_cnt.
REQ-011 SHIFT: on the edge delivering bit INST_W, SHALL load opcode/imm from the full frame, set inst_done=1, clear bit_cnt to 0 and go to READY, all in the same clk edge.
REQ-012 SHIFT: SHALL reset the idle counter on every serial edge.
REQ-013 SHIFT: when the idle counter reaches TIMEOUT_CYCLES, SHALL discard the partial frame, clear bit_cnt, pulse frame_err for 1 cycle and go to IDLE; opcode/imm SHALL be unchanged.
REQ-014 SHIFT: if a serial edge and a timeout occur in the same cycle, the serial edge SHALL win and no abort SHALL occur.
REQ-015 READY: SHALL hold inst_done=1 and keep opcode/imm stable.
REQ-016 READY: on a serial edge with exec_busy=0, SHALL clear inst_done, shift in bit 1, set bit_cnt=1 and go to SHIFT.
REQ-017 While exec_busy=1, SHALL ignore serial edges in every state, with no shift, no count and no state change.
REQ-018 opcode/imm SHALL change only on frame completion; they keep the previous frame during a reload.
REQ-019 btn_edge SHALL pulse for exactly 1 cycle on each rising edge of the conditioned button level, independent of state and exec_busy.
REQ-020 Holding the button SHALL produce no further btn_edge pulses.

Reset
REQ-021 While rstn=0, SHALL clear asynchronously: state=IDLE, opcode=0, imm=0, inst_done=0, btn_edge=0, frame_err=0, bit_cnt=0, shift register, idle counter, synchronizers and debounce state.
REQ-022 Reset mid-frame SHALL discard the partial frame.
REQ-023 No btn_edge SHALL be generated by a button already held high at reset release.

Configuration
REQ-024 Macro INST_LOADER_DEBOUNCE_EN, when defined: the conditioned button level SHALL change only after synced btn_in differs from it for DEBOUNCE_CYCLES consecutive cycles; any reversion within the window restarts the count.
REQ-025 Macro INST_LOADER_DEBOUNCE_EN, when not defined: the conditioned button level SHALL equal synced btn_in, and DEBOUNCE_CYCLES has no effect.

Verification
REQ-026 Reset, then send 12 serial bits 1000_0000_0101 -> after the 12th edge inst_done=1, opcode=4'b1000, imm=8'h05, bit_cnt=0.
REQ-027 Frame 0x6A3 loaded, exec_busy=1, then 12 serial edges -> opcode=6, imm=A3, inst_done=1 throughout, bit_cnt=0.
REQ-028 Send 5 bits, then idle 1024 cycles -> one frame_err pulse, state IDLE, opcode/imm unchanged; a following full frame loads correctly.
REQ-029 Press button bouncing 3 times within 10 cycles, then hold 40 cycles -> with INST_LOADER_DEBOUNCE_EN defined exactly one btn_edge; without it three btn_edge pulses.
REQ-030 Assert rstn=0 after 7 of 12 bits -> all outputs 0 immediately; after release, a full frame 0x1FF gives opcode=1, imm=FF.
